// File: rtl/jogo_pkg.sv
// Shared definitions for the parametrised sequence-memory game core.
// Holds the state encoding (codes match the debug 7-segment display),
// the sequence-memory content function and a constant clog2 helper.
package jogo_pkg;

  // Widest button vector the core supports; the memory function works at
  // this width and callers cut the result down to N_BOTOES.
  localparam int MAX_BOTOES = 8;

  typedef enum logic [3:0] {
    ST_INICIAL     = 4'h0,
    ST_PREPARACAO  = 4'h1,
    ST_ESPERA      = 4'h2,
    ST_REGISTRA    = 4'h4,
    ST_COMPARA     = 4'h5,
    ST_PROX_JOGADA = 4'h6,
    ST_PROX_RODADA = 4'h7,
    ST_FIM_ACERTO  = 4'hA,
    ST_FIM_TIMEOUT = 4'hD,
    ST_FIM_ERRO    = 4'hE
  } estado_t;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Sequence entry i is the one-hot code of button (i mod n_botoes).
  function automatic logic [MAX_BOTOES-1:0] palavra_memoria(input int indice,
                                                            input int n_botoes);
    logic [MAX_BOTOES-1:0] um;
    um = {{(MAX_BOTOES-1){1'b0}}, 1'b1};
    return um << (indice % n_botoes);
  endfunction

endpackage

// File: rtl/jogo_sequencia_fd.sv
// Datapath of the sequence game: play index counter, round register,
// play register, press edge detector, play timeout timer, sequence ROM
// (synchronous read at the play index) and the play/memory comparator.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   botoes_i            raw button vector
//   zera_i              clear index/play/round for a new game
//   modo_i              round mode captured for this game (0 full, 1 progressive)
//   registra_i          load play register
//   conta_jogada_i      advance play index
//   conta_rodada_i      advance round, restart index
//   conta_timer_i       timer runs while high, clears otherwise
//   contador_o, rodada_o, jogada_o, memoria_o   datapath registers
//   tem_jogada_o        one-cycle new-press pulse
//   igual_o             play matches memory word
//   fim_rodada_o        index reached the last play of the round
//   ultima_rodada_o     round is the final one
//   estouro_o           timer at its last waiting cycle
module jogo_sequencia_fd
  import jogo_pkg::*;
#(
  parameter int N_BOTOES       = 4,
  parameter int PROFUNDIDADE   = 16,
  parameter int TIMEOUT_CICLOS = 5000,
  localparam int AW = clog2(PROFUNDIDADE)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_BOTOES-1:0] botoes_i,
  input  logic                zera_i,
  input  logic                modo_i,
  input  logic                registra_i,
  input  logic                conta_jogada_i,
  input  logic                conta_rodada_i,
  input  logic                conta_timer_i,
  output logic [AW-1:0]       contador_o,
  output logic [AW-1:0]       rodada_o,
  output logic [N_BOTOES-1:0] jogada_o,
  output logic [N_BOTOES-1:0] memoria_o,
  output logic                tem_jogada_o,
  output logic                igual_o,
  output logic                fim_rodada_o,
  output logic                ultima_rodada_o,
  output logic                estouro_o
);

  localparam int TW   = (TIMEOUT_CICLOS < 2) ? 1 : clog2(TIMEOUT_CICLOS);
  localparam int TMAX = (TIMEOUT_CICLOS == 0) ? 0 : TIMEOUT_CICLOS - 1;
  localparam logic [AW-1:0] ULTIMO = AW'(PROFUNDIDADE - 1);

  logic [AW-1:0]       contador_q, contador_d;
  logic [AW-1:0]       rodada_q, rodada_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic [N_BOTOES-1:0] botoes_q;
  logic                tem_jogada_q;
  logic [N_BOTOES-1:0] memoria_q;
  logic [TW-1:0]       timer_q, timer_d;

  always_comb begin
    contador_d = contador_q;
    rodada_d   = rodada_q;
    jogada_d   = jogada_q;
    if (zera_i) begin
      contador_d = '0;
      jogada_d   = '0;
      rodada_d   = modo_i ? '0 : ULTIMO;
    end else begin
      if (conta_jogada_i) contador_d = contador_q + 1'b1;
      if (conta_rodada_i) begin
        contador_d = '0;
        rodada_d   = rodada_q + 1'b1;
      end
      // botoes_q still holds the press that produced tem_jogada.
      if (registra_i) jogada_d = botoes_q;
    end
    timer_d = conta_timer_i ? timer_q + TW'(1) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      contador_q   <= '0;
      rodada_q     <= '0;
      jogada_q     <= '0;
      botoes_q     <= '0;
      tem_jogada_q <= 1'b0;
      memoria_q    <= N_BOTOES'(palavra_memoria(0, N_BOTOES));
      timer_q      <= '0;
    end else begin
      contador_q   <= contador_d;
      rodada_q     <= rodada_d;
      jogada_q     <= jogada_d;
      botoes_q     <= botoes_i;
      tem_jogada_q <= (botoes_i != '0) && (botoes_q == '0);
      memoria_q    <= N_BOTOES'(palavra_memoria(int'(contador_q), N_BOTOES));
      timer_q      <= timer_d;
    end
  end

  assign contador_o      = contador_q;
  assign rodada_o        = rodada_q;
  assign jogada_o        = jogada_q;
  assign memoria_o       = memoria_q;
  assign tem_jogada_o    = tem_jogada_q;
  assign igual_o         = (jogada_q == memoria_q);
  assign fim_rodada_o    = (contador_q == rodada_q);
  assign ultima_rodada_o = (rodada_q == ULTIMO);
  assign estouro_o       = (TIMEOUT_CICLOS != 0) && (timer_q == TW'(TMAX));

endmodule

// File: rtl/jogo_sequencia_param.sv
// Top of the parametrised sequence game: control FSM plus datapath.
// Ports:
//   clock_i, reset_ni   clock, async active-low reset
//   iniciar_i           start/restart request (level)
//   modo_i              0 full sequence, 1 progressive rounds
//   botoes_i            button vector
//   pronto_o, acertou_o, errou_o, timeout_o   game result flags
//   leds_o              last registered play
//   db_*_o              debug taps (state code, index, round, memory word,
//                       new-play pulse, comparator)
//
// state          | meaning
// inicial        | idle after reset
// preparacao     | clear datapath, load round per mode
// espera_jogada  | wait for a press, timer running
// registra       | load play register
// compara        | check play against memory
// proxima_jogada | advance play index
// proxima_rodada | advance round, restart index
// fim_acerto     | whole sequence reproduced
// fim_erro       | wrong play
// fim_timeout    | no play within the timeout
module jogo_sequencia_param
  import jogo_pkg::*;
#(
  parameter int N_BOTOES       = 4,
  parameter int PROFUNDIDADE   = 16,
  parameter int TIMEOUT_CICLOS = 5000,
  localparam int AW = clog2(PROFUNDIDADE)
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic                iniciar_i,
  input  logic                modo_i,
  input  logic [N_BOTOES-1:0] botoes_i,
  output logic                pronto_o,
  output logic                acertou_o,
  output logic                errou_o,
  output logic                timeout_o,
  output logic [N_BOTOES-1:0] leds_o,
  output logic [3:0]          db_estado_o,
  output logic [AW-1:0]       db_contagem_o,
  output logic [AW-1:0]       db_rodada_o,
  output logic [N_BOTOES-1:0] db_memoria_o,
  output logic                db_tem_jogada_o,
  output logic                db_igual_o
);

  estado_t state_q, state_d;
  logic    modo_q;
  logic    pronto_q, acertou_q, errou_q, timeout_q;

  logic tem_jogada, igual, fim_rodada, ultima_rodada, estouro;
  logic ocioso;

  assign ocioso = (state_q == ST_INICIAL)    || (state_q == ST_FIM_ACERTO) ||
                  (state_q == ST_FIM_ERRO)   || (state_q == ST_FIM_TIMEOUT);

  jogo_sequencia_fd #(
    .N_BOTOES       (N_BOTOES),
    .PROFUNDIDADE   (PROFUNDIDADE),
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
  ) u_fd (
    .clk_i           (clock_i),
    .rst_ni          (reset_ni),
    .botoes_i        (botoes_i),
    .zera_i          (state_q == ST_PREPARACAO),
    .modo_i          (modo_q),
    .registra_i      (state_q == ST_REGISTRA),
    .conta_jogada_i  (state_q == ST_PROX_JOGADA),
    .conta_rodada_i  (state_q == ST_PROX_RODADA),
    .conta_timer_i   (state_q == ST_ESPERA),
    .contador_o      (db_contagem_o),
    .rodada_o        (db_rodada_o),
    .jogada_o        (leds_o),
    .memoria_o       (db_memoria_o),
    .tem_jogada_o    (tem_jogada),
    .igual_o         (igual),
    .fim_rodada_o    (fim_rodada),
    .ultima_rodada_o (ultima_rodada),
    .estouro_o       (estouro)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INICIAL:     if (iniciar_i) state_d = ST_PREPARACAO;
      ST_PREPARACAO:  state_d = ST_ESPERA;
      // A press wins over an expiring timer in the same cycle.
      ST_ESPERA: begin
        if (tem_jogada)   state_d = ST_REGISTRA;
        else if (estouro) state_d = ST_FIM_TIMEOUT;
      end
      ST_REGISTRA:    state_d = ST_COMPARA;
      ST_COMPARA: begin
        if (!igual)              state_d = ST_FIM_ERRO;
        else if (!fim_rodada)    state_d = ST_PROX_JOGADA;
        else if (ultima_rodada)  state_d = ST_FIM_ACERTO;
        else                     state_d = ST_PROX_RODADA;
      end
      ST_PROX_JOGADA: state_d = ST_ESPERA;
      ST_PROX_RODADA: state_d = ST_ESPERA;
      ST_FIM_ACERTO,
      ST_FIM_ERRO,
      ST_FIM_TIMEOUT: if (iniciar_i) state_d = ST_PREPARACAO;
      default:        state_d = ST_INICIAL;
    endcase
  end

  // Flags are decoded from the next state so they line up with state_q.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_INICIAL;
      modo_q    <= 1'b0;
      pronto_q  <= 1'b0;
      acertou_q <= 1'b0;
      errou_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ocioso && iniciar_i) modo_q <= modo_i;
      pronto_q  <= (state_d == ST_FIM_ACERTO) || (state_d == ST_FIM_ERRO) ||
                   (state_d == ST_FIM_TIMEOUT);
      acertou_q <= (state_d == ST_FIM_ACERTO);
      errou_q   <= (state_d == ST_FIM_ERRO) || (state_d == ST_FIM_TIMEOUT);
      timeout_q <= (state_d == ST_FIM_TIMEOUT);
    end
  end

  assign pronto_o        = pronto_q;
  assign acertou_o       = acertou_q;
  assign errou_o         = errou_q;
  assign timeout_o       = timeout_q;
  assign db_estado_o     = state_q;
  assign db_tem_jogada_o = tem_jogada;
  assign db_igual_o      = igual;

endmodule
